// File: rtl/kdf11_arb.sv
// kdf11_arb: CPU/DMA arbiter for the KDF11 single Wishbone master port.
// Define KDF11_ARB_TIMEOUT_EN to build the bus-timeout counter, bus_err and synthetic ack.
module kdf11_arb #(
    parameter int DMA_BURST  = 4,
    parameter int TMO_CYCLES = 255
) (
    input  logic clk_p,
    input  logic dclo,
    input  logic cpu_req,
    output logic cpu_gnt,
    output logic cpu_ack,
    input  logic dma_req,
    input  logic dma_stb,
    output logic dma_gnt,
    output logic dma_wb_ack,
    output logic sel_dma,
    input  logic bus_ack,
    output logic bus_err
);

    typedef enum logic {
        ST_CPU = 1'b0,
        ST_DMA = 1'b1
    } state_e;

    localparam logic [3:0] BURST_MAX = 4'(DMA_BURST);

    state_e     state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic       cpu_owed_q, cpu_owed_d;
    logic       owner_stb;
    logic       tmo_hit;
    logic       routed_ack;

    // Grants decode a single state flop, so they can never overlap.
    assign cpu_gnt = (state_q == ST_CPU);
    assign dma_gnt = (state_q == ST_DMA);
    assign sel_dma = dma_gnt;

    assign owner_stb  = (state_q == ST_DMA) ? dma_stb : cpu_req;
    assign routed_ack = owner_stb & (bus_ack | tmo_hit);
    assign cpu_ack    = routed_ack & (state_q == ST_CPU);
    assign dma_wb_ack = routed_ack & (state_q == ST_DMA);
    assign bus_err    = tmo_hit;

    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        cpu_owed_d = cpu_owed_q;
        if (state_q == ST_CPU) begin
            if (cpu_ack || !cpu_req)
                cpu_owed_d = 1'b0;
            if (dma_req && !cpu_req && !cpu_owed_q) begin
                state_d = ST_DMA;
                burst_d = '0;
            end
        end else begin
            if (dma_wb_ack && (burst_q != BURST_MAX))
                burst_d = burst_q + 4'd1;
            if (!dma_stb && !dma_req)
                state_d = ST_CPU;
            // Burst quota spent with the CPU waiting: hand over and owe it one cycle.
            if (!dma_stb && cpu_req && (burst_q == BURST_MAX)) begin
                state_d    = ST_CPU;
                cpu_owed_d = 1'b1;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously on dclo.
    always_ff @(posedge clk_p or posedge dclo) begin
        if (dclo) begin
            state_q    <= ST_CPU;
            burst_q    <= '0;
            cpu_owed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            cpu_owed_q <= cpu_owed_d;
        end
    end

`ifdef KDF11_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    logic [7:0] tmo_q, tmo_d;

    // tmo_q counts completed unacked strobe cycles; the TMO_CYCLES-th one fires.
    assign tmo_hit = owner_stb & ~bus_ack & (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = tmo_q + 8'd1;
        if ((state_d != state_q) || !owner_stb || routed_ack)
            tmo_d = '0;
    end

    always_ff @(posedge clk_p or posedge dclo) begin
        if (dclo)
            tmo_q <= '0;
        else
            tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_kdf11_arb.sv
// Self-checking bench for kdf11_arb: vector table, directed corner sequences,
// and a randomized run checked against a transaction-level arbitration model.
module tb_kdf11_arb;

    localparam int BURST = 4;
    localparam int TMO   = 16;
`ifdef KDF11_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk_p = 1'b0;
    logic dclo, cpu_req, dma_req, dma_stb, bus_ack;
    logic cpu_gnt, cpu_ack, dma_gnt, dma_wb_ack, sel_dma, bus_err;

    kdf11_arb #(.DMA_BURST(BURST), .TMO_CYCLES(TMO)) dut (
        .clk_p(clk_p), .dclo(dclo),
        .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_stb(dma_stb), .dma_gnt(dma_gnt),
        .dma_wb_ack(dma_wb_ack), .sel_dma(sel_dma),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk_p = ~clk_p;

    int n_tests = 0;
    int n_fail  = 0;

    // {cpu_req, dma_req, dma_stb, bus_ack, exp cpu_gnt, exp dma_gnt, exp cpu_ack, exp dma_wb_ack}
    typedef struct packed {
        logic cr, dr, ds, ba;
        logic cg, dg, ca, da;
    } vec_t;
    vec_t vecs[25];

    // Reference model: who owns the bus, transfers this tenure, debt to CPU, unacked cycles.
    bit m_dma_owner;
    int m_xfers;
    bit m_owed;
    int m_wait;
    bit e_cpu_ack, e_dma_ack, e_tmo, e_stb;

    int  n_acks, n_cpu_acks, early;
    bit  done;
    bit  prev_cpu_ack, prev_dma_ack;
    logic [7:0] exp_v;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {2'b00, cpu_gnt, dma_gnt, sel_dma, cpu_ack, dma_wb_ack, bus_err};
    endfunction

    // Apply {cpu_req, dma_req, dma_stb, bus_ack} for one cycle; returns with outputs settled.
    task automatic cyc(input logic [3:0] in_v);
        @(negedge clk_p);
        {cpu_req, dma_req, dma_stb, bus_ack} = in_v;
        #1;
    endtask

    task automatic model_reset();
        m_dma_owner = 1'b0;
        m_xfers     = 0;
        m_owed      = 1'b0;
        m_wait      = 0;
    endtask

    task automatic model_eval(output logic [7:0] exp);
        e_stb     = m_dma_owner ? dma_stb : cpu_req;
        e_tmo     = TMO_EN && e_stb && !bus_ack && (m_wait == TMO - 1);
        e_cpu_ack = e_stb && (bus_ack || e_tmo) && !m_dma_owner;
        e_dma_ack = e_stb && (bus_ack || e_tmo) && m_dma_owner;
        exp = {2'b00, !m_dma_owner, m_dma_owner, m_dma_owner, e_cpu_ack, e_dma_ack, e_tmo};
    endtask

    task automatic model_step();
        bit next_owner;
        next_owner = m_dma_owner;
        if (!m_dma_owner) begin
            if (dma_req && !cpu_req && !m_owed) begin
                next_owner = 1'b1;
                m_xfers    = 0;
            end
            if (e_cpu_ack || !cpu_req) m_owed = 1'b0;
        end else begin
            if (!dma_stb && !dma_req) next_owner = 1'b0;
            if (!dma_stb && cpu_req && m_xfers >= BURST) begin
                next_owner = 1'b0;
                m_owed     = 1'b1;
            end
            if (e_dma_ack) m_xfers = (m_xfers + 1 > BURST) ? BURST : m_xfers + 1;
        end
        if (next_owner != m_dma_owner || !e_stb || e_cpu_ack || e_dma_ack)
            m_wait = 0;
        else
            m_wait = m_wait + 1;
        m_dma_owner = next_owner;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = 8'b0000_1000;  // idle, parked on CPU
        vecs[1]  = 8'b0100_1000;  // dma_req sampled
        vecs[2]  = 8'b0100_0100;  // granted next edge
        vecs[3]  = 8'b0110_0100;
        vecs[4]  = 8'b0111_0101;  // DMA cycle 1 acked
        vecs[5]  = 8'b0100_0100;
        vecs[6]  = 8'b0110_0100;
        vecs[7]  = 8'b0111_0101;  // DMA cycle 2
        vecs[8]  = 8'b0100_0100;
        vecs[9]  = 8'b0110_0100;
        vecs[10] = 8'b0111_0101;  // DMA cycle 3
        vecs[11] = 8'b0000_0100;  // release sampled
        vecs[12] = 8'b0001_1000;  // back on CPU; stray ack dropped
        vecs[13] = 8'b1100_1000;  // collision: CPU wins
        vecs[14] = 8'b1101_1010;  // CPU acked
        vecs[15] = 8'b0100_1000;  // cpu_req low sampled
        vecs[16] = 8'b0100_0100;  // DMA granted
        vecs[17] = 8'b0000_0100;
        vecs[18] = 8'b0000_1000;
        vecs[19] = 8'b0100_1000;
        vecs[20] = 8'b1100_0100;  // CPU pending behind DMA
        vecs[21] = 8'b1101_0100;  // ack with no owner strobe dropped
        vecs[22] = 8'b1000_0100;  // DMA releases
        vecs[23] = 8'b1001_1010;  // pending CPU cycle acked
        vecs[24] = 8'b0000_1000;

        dclo = 1'b1;
        {cpu_req, dma_req, dma_stb, bus_ack} = 4'b0000;
        #1;
        check("reset_async", outs(), 8'b0010_0000);
        @(negedge clk_p);
        dclo = 1'b0;

        for (int i = 0; i < 25; i++) begin
            cyc({vecs[i].cr, vecs[i].dr, vecs[i].ds, vecs[i].ba});
            check($sformatf("vec%0d", i), outs(),
                  {2'b00, vecs[i].cg, vecs[i].dg, vecs[i].dg, vecs[i].ca, vecs[i].da, 1'b0});
        end

        // Forced release after BURST transfers while the CPU waits.
        cyc(4'b0100);
        check("force_pre_gnt", 8'(dma_gnt), 8'd0);
        n_acks = 0; n_cpu_acks = 0; done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk_p);
            if (!dma_gnt) begin
                done = 1'b1;
            end else begin
                cpu_req = 1'b1; dma_req = 1'b1;
                dma_stb = (i % 3 != 2);
                bus_ack = (i % 3 == 1);
                #1;
                if (dma_wb_ack) n_acks++;
                if (cpu_ack) n_cpu_acks++;
            end
        end
        check("force_released", 8'(done), 8'd1);
        check("force_dma_acks", 8'(n_acks), 8'(BURST));
        check("force_no_cpu_ack", 8'(n_cpu_acks), 8'd0);
        check("force_cpu_gnt", 8'(cpu_gnt), 8'd1);
        bus_ack = 1'b1; dma_stb = 1'b0;
        #1;
        check("force_cpu_cycle", {5'b0, cpu_gnt, cpu_ack, dma_gnt}, 8'b0000_0110);
        cyc(4'b0100);
        check("force_regrant_wait", 8'(dma_gnt), 8'd0);
        cyc(4'b0100);
        check("force_regrant", 8'(dma_gnt), 8'd1);
        cyc(4'b0000);
        cyc(4'b0000);
        check("force_back_cpu", 8'(cpu_gnt), 8'd1);

        // Hung CPU cycle: timeout on the TMO-th cycle, or a stall without the counter.
        early = 0;
        for (int k = 1; k <= TMO; k++) begin
            cyc(4'b1000);
            if (k < TMO) early += int'(bus_err | cpu_ack);
            else check("tmo_hit", {6'b0, bus_err, cpu_ack}, TMO_EN ? 8'b11 : 8'b00);
        end
        check("tmo_no_early", 8'(early), 8'd0);
        cyc(4'b0000);
        early = 0;
        for (int k = 1; k <= TMO; k++) begin
            cyc({3'b100, k == TMO});
            if (k < TMO) early += int'(bus_err | cpu_ack);
            else check("tmo_real_ack", {6'b0, bus_err, cpu_ack}, 8'b01);
        end
        check("tmo_real_no_early", 8'(early), 8'd0);
        cyc(4'b0000);

        // Reset in the middle of a DMA cycle.
        cyc(4'b0100);
        cyc(4'b0110);
        check("rst_dma_owner", 8'(dma_gnt), 8'd1);
        #2 dclo = 1'b1;
        #1;
        check("rst_mid_dma", {4'b0, cpu_gnt, dma_gnt, sel_dma, bus_err}, 8'b0000_1000);
        cyc(4'b0000);
        cyc(4'b0000);
        @(negedge clk_p);
        dclo = 1'b0;
        cyc(4'b0100);
        check("rst_regrant_wait", 8'(dma_gnt), 8'd0);
        cyc(4'b0100);
        check("rst_regrant", 8'(dma_gnt), 8'd1);
        cyc(4'b0000);
        cyc(4'b0000);

        // Randomized run against the model.
        @(negedge clk_p);
        dclo = 1'b1;
        {cpu_req, dma_req, dma_stb, bus_ack} = 4'b0000;
        @(negedge clk_p);
        dclo = 1'b0;
        model_reset();
        prev_cpu_ack = 1'b0;
        prev_dma_ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_p);
            if (cpu_req && prev_cpu_ack) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(3) == 0) cpu_req = 1'b1;
            if (dma_stb && prev_dma_ack) dma_stb = 1'b0;
            else if (!dma_stb && m_dma_owner && dma_req && $urandom_range(2) == 0) dma_stb = 1'b1;
            if (!dma_req && $urandom_range(4) == 0) dma_req = 1'b1;
            else if (dma_req && !dma_stb && $urandom_range(5) == 0) dma_req = 1'b0;
            bus_ack = (i < 1500) ? ($urandom_range(2) == 0) : ($urandom_range(23) == 0);
            #1;
            model_eval(exp_v);
            check("rand", outs(), exp_v);
            prev_cpu_ack = e_cpu_ack;
            prev_dma_ack = e_dma_ack;
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
